// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-wide data memory without byte enables; SB/SH use read-modify-write.
// Define LSU_COUNTERS_EN to add the ld_count/st_count completion counters.
module load_store_unit #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] RAM_LIMIT = 32'h00010000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misalign,
    output logic              rsp_illegal,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_data_out,
    output logic              mem_we,
    input  logic [31:0]       mem_data_in
`ifdef LSU_COUNTERS_EN
    ,
    output logic [31:0]       ld_count,
    output logic [31:0]       st_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         merge_q, merge_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_misalign_q, rsp_misalign_d;
    logic                rsp_illegal_q, rsp_illegal_d;

    logic                accept;
    logic                req_illegal;
    logic                req_misalign;
    logic [31:0]         addr_ext;
    logic                in_range;
    logic [31:0]         rd_word;
    logic [7:0]          lane_byte;
    logic [15:0]         lane_half;
    logic [31:0]         load_data;
    logic [31:0]         merged;

    assign addr_ext = 32'(addr_q);
    assign in_range = (addr_ext < RAM_LIMIT);

    // Out-of-range accesses never see the bus value, so loads extend a zero word.
    assign rd_word = in_range ? mem_data_in : 32'h0;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_illegal  = 1'b0;
        req_misalign = 1'b0;
        if (req_we) begin
            req_illegal = (req_funct3 >= 3'd3);
        end else begin
            req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
        if (!req_illegal) begin
            req_misalign = ((req_funct3[1:0] == 2'd1) && req_addr[0])
                        || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
        end
    end

    always_comb begin
        lane_byte = rd_word[7:0];
        case (addr_q[1:0])
            2'd0:    lane_byte = rd_word[7:0];
            2'd1:    lane_byte = rd_word[15:8];
            2'd2:    lane_byte = rd_word[23:16];
            default: lane_byte = rd_word[31:24];
        endcase
        lane_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q)
            3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
            3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
            3'd2:    load_data = rd_word;
            3'd4:    load_data = {24'h0, lane_byte};
            3'd5:    load_data = {16'h0, lane_half};
            default: load_data = 32'h0;
        endcase
    end

    // Only the addressed byte/halfword of the captured word is replaced by store data.
    always_comb begin
        merged = merge_q;
        if (funct3_q[1:0] == 2'd0) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0]  = wdata_q[15:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        funct3_d       = funct3_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        merge_d        = merge_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_misalign_d = rsp_misalign_q;
        rsp_illegal_d  = rsp_illegal_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    if (req_illegal || req_misalign) begin
                        rsp_valid_d    = 1'b1;
                        rsp_rdata_d    = 32'h0;
                        rsp_misalign_d = req_misalign;
                        rsp_illegal_d  = req_illegal;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == 3'd2) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                state_d        = IDLE;
                rsp_valid_d    = 1'b1;
                rsp_rdata_d    = load_data;
                rsp_misalign_d = 1'b0;
                rsp_illegal_d  = 1'b0;
            end
            RMW_RD: begin
                merge_d = rd_word;
                state_d = RMW_WR;
            end
            WRITE, RMW_WR: begin
                state_d        = IDLE;
                rsp_valid_d    = 1'b1;
                rsp_rdata_d    = 32'h0;
                rsp_misalign_d = 1'b0;
                rsp_illegal_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            funct3_q       <= 3'd0;
            we_q           <= 1'b0;
            wdata_q        <= 32'h0;
            merge_q        <= 32'h0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 32'h0;
            rsp_misalign_q <= 1'b0;
            rsp_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            funct3_q       <= funct3_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            merge_q        <= merge_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_misalign_q <= rsp_misalign_d;
            rsp_illegal_q  <= rsp_illegal_d;
        end
    end

    // The write strobe is gated by reset so an aborted store never reaches memory.
    always_comb begin
        mem_address  = (state_q == IDLE) ? 32'h0 : {addr_ext[31:2], 2'b00};
        mem_data_out = 32'h0;
        if (state_q == WRITE) begin
            mem_data_out = wdata_q;
        end else if (state_q == RMW_WR) begin
            mem_data_out = merged;
        end
        mem_we = ((state_q == WRITE) || (state_q == RMW_WR)) && !rst && in_range;
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_misalign = rsp_misalign_q;
    assign rsp_illegal  = rsp_illegal_q;

`ifdef LSU_COUNTERS_EN
    logic [31:0] ld_count_q, ld_count_d;
    logic [31:0] st_count_q, st_count_d;

    // LOAD/WRITE/RMW_WR always complete on their next edge unless reset clears everything anyway.
    always_comb begin
        ld_count_d = ld_count_q + 32'((state_q == LOAD));
        st_count_d = st_count_q + 32'(((state_q == WRITE) || (state_q == RMW_WR)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_count_q <= 32'h0;
            st_count_q <= 32'h0;
        end else begin
            ld_count_q <= ld_count_d;
            st_count_q <= st_count_d;
        end
    end

    assign ld_count = ld_count_q;
    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model predicts every response and
// memory write cycle by cycle; directed cases pin the model, then randomized traffic runs against it.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam logic [31:0] LIMIT = 32'h00010000;
    localparam int WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_illegal;
    logic [31:0] mem_address;
    logic [31:0] mem_data_out;
    logic        mem_we;
    logic [31:0] mem_data_in;
`ifdef LSU_COUNTERS_EN
    logic [31:0] ld_count;
    logic [31:0] st_count;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accCycle = 0;

    always #5 clk = ~clk;

    // Period index: everything after posedge k and before posedge k+1 is cycle k.
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit #(.ADDR_W(32), .RAM_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign),
        .rsp_illegal(rsp_illegal),
        .mem_address(mem_address),
        .mem_data_out(mem_data_out),
        .mem_we(mem_we),
        .mem_data_in(mem_data_in)
`ifdef LSU_COUNTERS_EN
        ,
        .ld_count(ld_count),
        .st_count(st_count)
`endif
    );

    // Deterministic initial memory image, shared by the memory and the model.
    function automatic logic [31:0] initWord(int idx);
        logic [31:0] v;
        if (idx == 32'h40) return 32'h843322F1;
        if (idx == 32'h80) return 32'hCAFEF00D;
        v = 32'(idx) * 32'h9E3779B1;
        return v ^ 32'h5A5A0F0F;
    endfunction

    // The data memory: combinational read, synchronous write, junk beyond the RAM so stray reads show up.
    logic [31:0] ram [WORDS];
    logic        ramInit = 1'b0;
    always @(posedge clk) begin
        if (!ramInit) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= initWord(i);
            ramInit <= 1'b1;
        end else if (mem_we && (mem_address < LIMIT)) begin
            ram[mem_address[15:2]] <= mem_data_out;
        end
    end
    assign mem_data_in = (mem_address < LIMIT) ? ram[mem_address[15:2]] : 32'hA5A5A5A5;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
        end
    endtask

    // Reference rules for loads: shift the addressed lane down, mask to size, then extend.
    function automatic logic [31:0] loadValue(logic [31:0] word, logic [2:0] f3, logic [1:0] off);
        int size;
        logic [31:0] v;
        logic [31:0] mask;
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        v = word >> (8 * off);
        if (size == 4) return v;
        mask = (32'h1 << (8 * size)) - 32'h1;
        v = v & mask;
        if (!f3[2] && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference rules for stores: overwrite the bytes covered by the access, keep the rest.
    function automatic logic [31:0] storeMerge(logic [31:0] old, logic [31:0] wd, logic [2:0] f3, logic [1:0] off);
        int size;
        logic [31:0] res;
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        res = old;
        for (int i = 0; i < size; i++) res[8*(int'(off)+i) +: 8] = wd[8*i +: 8];
        return res;
    endfunction

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        logic        isLd;
        logic        isSt;
    } rsp_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
    } wr_t;

    rsp_t        rspQ[$];
    wr_t         wrQ[$];
    logic [31:0] refMem [WORDS];
    logic        refInit = 1'b0;
    int          freeCycle = 0;
    int          ldExp = 0;
    int          stExp = 0;

    // The model and compare process: every cycle it checks the outputs predicted for this cycle,
    // then records any request accepted this cycle as future responses and memory writes.
    always @(negedge clk) begin : model
        rsp_t        r;
        wr_t         w;
        logic        ill;
        logic        mis;
        logic        inRange;
        int          idx;
        int          lat;
        logic [31:0] old;
        if (!refInit) begin
            for (int i = 0; i < WORDS; i++) refMem[i] = initWord(i);
            refInit = 1'b1;
        end
        if (cyc >= 1) begin
            if (rst) begin
                while (wrQ.size() > 0 && wrQ[$].cyc >= cyc) void'(wrQ.pop_back());
            end
            if (rspQ.size() > 0 && rspQ[0].cyc == cyc) begin
                r = rspQ.pop_front();
                checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
                checkOutput("rsp_rdata", rsp_rdata, r.rdata);
                checkOutput("rsp_misalign", 32'(rsp_misalign), 32'(r.mis));
                checkOutput("rsp_illegal", 32'(rsp_illegal), 32'(r.ill));
                if (r.isLd) ldExp++;
                if (r.isSt) stExp++;
            end else begin
                checkOutput("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
            end
`ifdef LSU_COUNTERS_EN
            checkOutput("ld_count", ld_count, 32'(ldExp));
            checkOutput("st_count", st_count, 32'(stExp));
`endif
            checkOutput("req_ready", 32'(req_ready), 32'((!rst) && (cyc >= freeCycle)));
            if (wrQ.size() > 0 && wrQ[0].cyc == cyc) begin
                w = wrQ.pop_front();
                checkOutput("mem_we", 32'(mem_we), 32'd1);
                checkOutput("mem_address_wr", mem_address, 32'(w.idx) << 2);
                checkOutput("mem_data_out_wr", mem_data_out, w.data);
                refMem[w.idx] = w.data;
            end else begin
                checkOutput("mem_we_quiet", 32'(mem_we), 32'd0);
            end
            if (cyc >= freeCycle) begin
                checkOutput("idle_mem_address", mem_address, 32'h0);
                checkOutput("idle_mem_data_out", mem_data_out, 32'h0);
            end
            if (!rst && req_valid && (cyc >= freeCycle)) begin
                ill = req_we ? (req_funct3 > 3'd2)
                             : ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7));
                mis = 1'b0;
                if (!ill) begin
                    if (req_funct3[1:0] == 2'd1) mis = req_addr[0];
                    if (req_funct3[1:0] == 2'd2) mis = (req_addr[1:0] != 2'b00);
                end
                inRange = (req_addr < LIMIT);
                idx = int'(req_addr[15:2]);
                old = inRange ? refMem[idx] : 32'h0;
                r.rdata = 32'h0;
                r.mis = mis;
                r.ill = ill;
                r.isLd = 1'b0;
                r.isSt = 1'b0;
                if (ill || mis) begin
                    lat = 1;
                end else if (!req_we) begin
                    lat = 2;
                    r.rdata = loadValue(old, req_funct3, req_addr[1:0]);
                    r.isLd = 1'b1;
                end else begin
                    lat = (req_funct3 == 3'd2) ? 2 : 3;
                    r.isSt = 1'b1;
                    if (inRange) begin
                        w.cyc = cyc + lat - 1;
                        w.idx = idx;
                        w.data = storeMerge(old, req_wdata, req_funct3, req_addr[1:0]);
                        wrQ.push_back(w);
                    end
                end
                r.cyc = cyc + lat;
                rspQ.push_back(r);
                freeCycle = cyc + lat;
            end
            if (rst) begin
                rspQ.delete();
                wrQ.delete();
                ldExp = 0;
                stExp = 0;
                freeCycle = cyc + 1;
            end
        end
    end

    // Present one request in the first cycle the unit is expected to be ready.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        while (cyc < freeCycle) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        accCycle = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Hand-computed expectation for the response of the most recent request.
    task automatic expectRsp(input string name, input int lat, input logic [31:0] data, input logic mis, input logic ill);
        int target;
        target = accCycle + lat;
        do @(negedge clk); while (cyc < target);
        checkOutput({name, "_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({name, "_rdata"}, rsp_rdata, data);
        checkOutput({name, "_misalign"}, 32'(rsp_misalign), 32'(mis));
        checkOutput({name, "_illegal"}, 32'(rsp_illegal), 32'(ill));
    endtask

    // Safety net in case anything stalls the clock-driven flow.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases with literal expectations first, then randomized traffic.
    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_misalign", 32'(rsp_misalign), 32'd0);
        checkOutput("reset_rsp_illegal", 32'(rsp_illegal), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_address", mem_address, 32'h0);

        applyStimulus(1'b0, 3'd0, 32'h100, 32'h0);
        expectRsp("lb_100", 2, 32'hFFFFFFF1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd4, 32'h103, 32'h0);
        expectRsp("lbu_103", 2, 32'h00000084, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd1, 32'h102, 32'h0);
        expectRsp("lh_102", 2, 32'hFFFF8433, 1'b0, 1'b0);

        applyStimulus(1'b1, 3'd2, 32'h100, 32'h11223344);
        expectRsp("sw_100", 2, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 32'h101, 32'h000000AB);
        expectRsp("sb_101", 3, 32'h0, 1'b0, 1'b0);
        checkOutput("sb_101_word", ram[32'h40], 32'h1122AB44);
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
        expectRsp("lw_100", 2, 32'h1122AB44, 1'b0, 1'b0);

        applyStimulus(1'b1, 3'd2, 32'hFFC, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd2, 32'hFFC, 32'h0);
        checkOutput("b2b_accept_cycle", 32'(accCycle), 32'(freeCycle - 2));
        expectRsp("lw_ffc_b2b", 2, 32'hDEADBEEF, 1'b0, 1'b0);

        applyStimulus(1'b0, 3'd2, 32'h102, 32'h0);
        expectRsp("lw_misalign", 1, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd5, 32'h104, 32'h12345678);
        expectRsp("st_illegal", 1, 32'h0, 1'b0, 1'b1);

        // Reset lands while the SH sits in its write cycle; the word must survive.
        applyStimulus(1'b1, 3'd1, 32'h200, 32'h0000BEEF);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_rmw_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_rmw_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rmw_no_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rmw_word", ram[32'h80], 32'hCAFEF00D);

        // Three loads, two stores and one fault after the reset, including out-of-range traffic.
        applyStimulus(1'b0, 3'd0, 32'h100, 32'h0);
        expectRsp("lb_after_rst", 2, 32'h00000044, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 32'h00010000, 32'h55555555);
        expectRsp("sw_out_of_range", 2, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 32'h00010000, 32'h0);
        expectRsp("lw_out_of_range", 2, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd5, 32'h1002, 32'h0);
        applyStimulus(1'b1, 3'd0, 32'h1003, 32'h000000C3);
        applyStimulus(1'b0, 3'd1, 32'h101, 32'h0);
        expectRsp("lh_misalign", 1, 32'h0, 1'b1, 1'b0);
`ifdef LSU_COUNTERS_EN
        checkOutput("ld_count_literal", ld_count, 32'd3);
        checkOutput("st_count_literal", st_count, 32'd2);
`endif

        // Random traffic, including requests offered while the unit is busy.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 2) != 0);
            req_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (req_we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            req_funct3 = f3;
            case ($urandom_range(0, 9))
                0: a = 32'h00010000 + 32'($urandom_range(0, 15));
                1: a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                default: a = 32'h1000 + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            req_addr = a;
            req_wdata = $urandom();
        end
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        for (int i = 32'h400; i < 32'h410; i++) begin
            checkOutput("final_ram_word", ram[i], refMem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Core-side initiator for the word-wide data memory: it accepts RV32I load/store requests from the MEM stage and drives the memory's address, data, and write-enable port.
- Data memory has combinational word read, synchronous word write, and no byte enables.
- Loads: extracts the byte/halfword and sign- or zero-extends it.
- SB/SH: performed as a two-cycle read-modify-write.
- Valid/ready request side and single-pulse response side, so the core can stall on busy.

Parameters:
ADDR_W, 32, request/memory address width
RAM_LIMIT, 32'h00010000, first address beyond RAM; loads at or above it return 0 without being read, stores are dropped, no fault

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bits used for SB/SH)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores and faults)
rsp_misalign  out  1  qualified by rsp_valid
rsp_illegal  out  1  qualified by rsp_valid; unsupported funct3
mem_address  out  32  to memory address, always word-aligned ({addr[31:2],2'b00})
mem_data_out  out  32  to memory data_in
mem_we  out  1  to memory we
mem_data_in  in  32  from memory data_out (combinational read)

Behaviour:
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR.
- Handshake and request latch:
  - A request is accepted when req_valid && req_ready.
  - addr, funct3, we and wdata are registered at acceptance.
- Reset (rst=1 at a posedge):
  - state becomes IDLE; rsp_valid, rsp_rdata, rsp_misalign and rsp_illegal become 0; latched request cleared.
  - req_ready is 0 while rst=1.
- Outputs in IDLE: mem_address=0, mem_data_out=0, mem_we=0.
- Write-enable gating: mem_we = (state==WRITE || state==RMW_WR) && !rst && in-range. No write occurs at the edge where reset is applied.
- Fault decode (at accept):
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Illegal: load funct3 3, 6 or 7; store funct3 >= 3.
  - Illegal takes priority over misaligned.
  - On a fault: stay IDLE, no memory access, rsp_valid=1 next cycle with the matching flag set and rsp_rdata=0.
- Load timing:
  - Accept in cycle 0 -> LOAD in cycle 1, with mem_address driven and mem_data_in sampled at the end of cycle 1.
  - rsp_valid high in cycle 2, state back to IDLE. Latency is 2 cycles.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- SW: accept -> WRITE (mem_we=1, mem_data_out=wdata) -> rsp_valid next cycle. Latency 2.
- SB/SH:
  - Accept -> RMW_RD: read the word and capture it in a merge register.
  - RMW_WR: mem_we=1; mem_data_out = merged word, with only the addressed byte/halfword replaced by wdata[7:0] or wdata[15:0].
  - rsp_valid the following cycle. Latency 3.
- Back-to-back: rsp_valid coincides with IDLE, so a new request may be accepted in the same cycle rsp_valid is high.
- rsp_valid is a single pulse with no backpressure; rsp_* registers hold their value until the next completion or reset.
- Out-of-range addresses (>= RAM_LIMIT) follow the normal state sequence and latency:
  - mem_we is held 0.
  - Loads return the extension of 0.
- Reset mid-operation (any non-IDLE state) aborts the operation: no write, no rsp_valid pulse.

Optional Feature:
- Macro: LSU_COUNTERS_EN.
- Defined: adds two output ports, ld_count[31:0] and st_count[31:0].
  - Counters increment on each non-faulting load/store completion (at the rsp_valid cycle).
  - They clear on rst and wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Memory word 0x100 = 0x8433_22F1. LB at 0x100 -> rsp_rdata 0xFFFF_FFF1 in cycle 2. LBU at 0x103 -> 0x0000_0084. LH at 0x102 -> 0xFFFF_8433.
- SB wdata 0xAB at 0x101 over word 0x1122_3344 -> mem_we pulses exactly once (cycle 2), writing 0x1122_AB44; rsp_valid in cycle 3. A following LW at 0x100 -> 0x1122_AB44.
- SW 0xDEAD_BEEF at 0x0FFC, then immediate LW from the same address accepted in the rsp_valid cycle -> 0xDEAD_BEEF. req_ready low during busy cycles.
- LW at 0x102 -> rsp_valid cycle 1, rsp_misalign=1, rsp_rdata=0, mem_we never asserted. Store funct3=5 -> rsp_illegal=1, rsp_misalign=0.
- SH at 0x200, then rst asserted while in RMW_WR -> mem_we=0 at that edge, word unchanged, no rsp_valid, req_ready=1 one cycle after rst drops.
- SW at 0x0001_0000 -> no mem_we, rsp_valid in cycle 2. With LSU_COUNTERS_EN defined: 3 loads + 2 stores + 1 fault -> ld_count=3, st_count=2.
